// File: rtl/data_combiner.sv
// Packs a UART byte stream MSB-first into 32-bit words and buffers them in a
// first-word-fall-through FIFO with a valid/ready output and a sticky overflow flag.
module data_combiner #(
  parameter int DEPTH = 16,
  parameter int LW    = 5
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [7:0]    data_i,
  input  logic          valid_pulse_i,
  input  logic          clr_i,
  input  logic          ready,
  output logic [31:0]   data_o,
  output logic          valid_o,
  output logic [LW-1:0] level_o,
  output logic          overflow_o
);

  localparam int AW = $clog2(DEPTH);

  logic [1:0]    byte_cnt;
  logic [23:0]   shift;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic          overflow;

  logic full;
  logic push;
  logic pop;
  logic push_ok;

  assign full    = (level == LW'(DEPTH));
  // A clear in the same cycle as the fourth byte restarts the word, so nothing is pushed.
  assign push    = valid_pulse_i && !clr_i && (byte_cnt == 2'd3);
  assign pop     = valid_o && ready;
  // When full, a simultaneous pop frees the head slot, which is the one being written.
  assign push_ok = push && (!full || pop);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      byte_cnt <= 2'd0;
      shift    <= 24'h0;
    end else if (clr_i) begin
      byte_cnt <= valid_pulse_i ? 2'd1 : 2'd0;
      shift    <= valid_pulse_i ? {16'h0, data_i} : 24'h0;
    end else if (valid_pulse_i) begin
      byte_cnt <= byte_cnt + 2'd1;
      shift    <= {shift[15:0], data_i};
    end
  end

  // NOTE: the storage array has no reset; the pointers and level define which
  // entries are meaningful, and data_o is a don't-care while valid_o is low.
  always_ff @(posedge clk) begin
    if (rstn && push_ok) begin
      mem[wr_ptr] <= {shift, data_i};
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (push && !push_ok) begin
        overflow <= 1'b1;
      end
    end
  end

  assign data_o     = mem[rd_ptr];
  assign valid_o    = (level != '0);
  assign level_o    = level;
  assign overflow_o = overflow;

endmodule
